// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the parametrised pipeline stage register.
package pipe_stage_reg_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013; // addi x0, x0, 0

    localparam int unsigned SKID_OFF = 0;
    localparam int unsigned SKID_ON  = 1;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones instead of wrapping.
module pipe_stage_reg_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional two-entry skid buffer and saturating performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned CTRL_W   = 16,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
    parameter int unsigned SKID     = SKID_OFF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       out_inst,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              valid_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [31:0]       main_inst_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = valid_q && out_ready;

    if (SKID == SKID_OFF) begin : g_single
        assign in_ready = out_ready || !valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q     <= 1'b0;
                main_data_q <= '0;
                main_ctrl_q <= '0;
                main_inst_q <= NOP_INST;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (in_fire) begin
                valid_q     <= 1'b1;
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
                main_inst_q <= in_inst;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end
    end else begin : g_skid
        skid_state_e       state_q;
        logic              ready_q;
        logic [DATA_W-1:0] skid_data_q;
        logic [CTRL_W-1:0] skid_ctrl_q;
        logic [31:0]       skid_inst_q;

        // Registered ready keeps out_ready off the combinational path to in_ready.
        assign in_ready = ready_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= StEmpty;
                valid_q     <= 1'b0;
                ready_q     <= 1'b1;
                main_data_q <= '0;
                main_ctrl_q <= '0;
                main_inst_q <= NOP_INST;
                skid_data_q <= '0;
                skid_ctrl_q <= '0;
                skid_inst_q <= '0;
            end else if (flush) begin
                state_q <= StEmpty;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    StEmpty: begin
                        if (in_fire) begin
                            state_q     <= StOne;
                            valid_q     <= 1'b1;
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                            main_inst_q <= in_inst;
                        end
                    end
                    StOne: begin
                        if (in_fire && out_fire) begin
                            main_data_q <= in_data;
                            main_ctrl_q <= in_ctrl;
                            main_inst_q <= in_inst;
                        end else if (in_fire) begin
                            state_q     <= StTwo;
                            ready_q     <= 1'b0;
                            skid_data_q <= in_data;
                            skid_ctrl_q <= in_ctrl;
                            skid_inst_q <= in_inst;
                        end else if (out_fire) begin
                            state_q <= StEmpty;
                            valid_q <= 1'b0;
                        end
                    end
                    StTwo: begin
                        if (out_fire) begin
                            state_q     <= StOne;
                            ready_q     <= 1'b1;
                            main_data_q <= skid_data_q;
                            main_ctrl_q <= skid_ctrl_q;
                            main_inst_q <= skid_inst_q;
                        end
                    end
                    default: begin
                        state_q <= StEmpty;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = valid_q ? main_ctrl_q : '0;
    assign out_inst  = valid_q ? main_inst_q : NOP_INST;

    pipe_stage_reg_sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (valid_q && !out_ready),
        .count(stall_cnt)
    );

    pipe_stage_reg_sat_counter #(
        .WIDTH(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (!valid_q),
        .count(bubble_cnt)
    );

    pipe_stage_reg_sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (flush),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=0 and SKID=1 stages plus a 4-bit-counter instance for saturation.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // SKID=0 instance
    logic          s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready;
    logic [DW-1:0] s0_in_data, s0_out_data;
    logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
    logic [31:0]   s0_in_inst, s0_out_inst;
    logic [7:0]    s0_stall, s0_bubble, s0_flushc;

    // SKID=1 instance
    logic          s1_in_valid, s1_in_ready, s1_flush, s1_out_valid, s1_out_ready;
    logic [DW-1:0] s1_in_data, s1_out_data;
    logic [CW-1:0] s1_in_ctrl, s1_out_ctrl;
    logic [31:0]   s1_in_inst, s1_out_inst;
    logic [7:0]    s1_stall, s1_bubble, s1_flushc;

    // Idle instance with 4-bit counters
    logic          s2_in_ready, s2_out_valid;
    logic [DW-1:0] s2_out_data;
    logic [CW-1:0] s2_out_ctrl;
    logic [31:0]   s2_out_inst;
    logic [3:0]    s2_stall, s2_bubble, s2_flushc;

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .NOP_INST(NOP), .SKID(0), .CNT_W(8)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .in_ctrl(s0_in_ctrl), .in_inst(s0_in_inst), .flush(s0_flush),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .out_ctrl(s0_out_ctrl), .out_inst(s0_out_inst),
        .stall_cnt(s0_stall), .bubble_cnt(s0_bubble), .flush_cnt(s0_flushc)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .NOP_INST(NOP), .SKID(1), .CNT_W(8)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
        .in_ctrl(s1_in_ctrl), .in_inst(s1_in_inst), .flush(s1_flush),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
        .out_ctrl(s1_out_ctrl), .out_inst(s1_out_inst),
        .stall_cnt(s1_stall), .bubble_cnt(s1_bubble), .flush_cnt(s1_flushc)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .NOP_INST(NOP), .SKID(1), .CNT_W(4)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(1'b0), .in_ready(s2_in_ready), .in_data('0),
        .in_ctrl('0), .in_inst(32'h0), .flush(1'b0),
        .out_valid(s2_out_valid), .out_ready(1'b0), .out_data(s2_out_data),
        .out_ctrl(s2_out_ctrl), .out_inst(s2_out_inst),
        .stall_cnt(s2_stall), .bubble_cnt(s2_bubble), .flush_cnt(s2_flushc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s0_in_valid = 1'b0; s0_in_data = '0; s0_in_ctrl = '0; s0_in_inst = '0;
        s0_flush = 1'b0; s0_out_ready = 1'b0;
        s1_in_valid = 1'b0; s1_in_data = '0; s1_in_ctrl = '0; s1_in_inst = '0;
        s1_flush = 1'b0; s1_out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_s0_valid", 64'(s0_out_valid), 64'd0);
        check_eq("rst_s0_ctrl", 64'(s0_out_ctrl), 64'd0);
        check_eq("rst_s0_inst", 64'(s0_out_inst), 64'(NOP));
        check_eq("rst_s0_data", 64'(s0_out_data), 64'd0);
        check_eq("rst_s0_ready", 64'(s0_in_ready), 64'd1);
        check_eq("rst_s0_bubble", 64'(s0_bubble), 64'd0);
        check_eq("rst_s1_ready", 64'(s1_in_ready), 64'd1);
        check_eq("rst_s1_valid", 64'(s1_out_valid), 64'd0);
        check_eq("rst_s1_stall", 64'(s1_stall), 64'd0);
        check_eq("rst_s1_flushc", 64'(s1_flushc), 64'd0);

        // Single entry through the SKID=0 stage
        s0_in_valid = 1'b1; s0_in_data = 16'hA5A5; s0_in_ctrl = 4'h3;
        s0_in_inst = 32'h00A0_0093; s0_out_ready = 1'b1;
        step();
        s0_in_valid = 1'b0;
        check_eq("single_valid", 64'(s0_out_valid), 64'd1);
        check_eq("single_data", 64'(s0_out_data), 64'hA5A5);
        check_eq("single_ctrl", 64'(s0_out_ctrl), 64'h3);
        check_eq("single_inst", 64'(s0_out_inst), 64'h00A0_0093);
        step();
        check_eq("drain_valid", 64'(s0_out_valid), 64'd0);
        check_eq("drain_ctrl", 64'(s0_out_ctrl), 64'd0);
        check_eq("drain_inst", 64'(s0_out_inst), 64'(NOP));
        check_eq("drain_data_hold", 64'(s0_out_data), 64'hA5A5);
        check_eq("drain_bubble", 64'(s0_bubble), 64'd1);
        check_eq("drain_stall", 64'(s0_stall), 64'd0);

        // SKID=0 combinational ready and back-to-back replacement
        s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_data = 16'h1111;
        s0_in_ctrl = 4'h1; s0_in_inst = 32'h11;
        step();
        s0_in_valid = 1'b0;
        check_eq("comb_valid", 64'(s0_out_valid), 64'd1);
        check_eq("comb_ready_lo", 64'(s0_in_ready), 64'd0);
        s0_out_ready = 1'b1;
        #1;
        check_eq("comb_ready_hi", 64'(s0_in_ready), 64'd1);
        s0_out_ready = 1'b0;
        #1;
        check_eq("comb_ready_lo2", 64'(s0_in_ready), 64'd0);
        s0_out_ready = 1'b1; s0_in_valid = 1'b1; s0_in_data = 16'h2222;
        s0_in_ctrl = 4'h2; s0_in_inst = 32'h22;
        step();
        s0_in_valid = 1'b0; s0_out_ready = 1'b0;
        check_eq("replace_valid", 64'(s0_out_valid), 64'd1);
        check_eq("replace_data", 64'(s0_out_data), 64'h2222);
        check_eq("replace_ctrl", 64'(s0_out_ctrl), 64'h2);
        check_eq("replace_bubble", 64'(s0_bubble), 64'd2);
        step();
        check_eq("s0_stall_one", 64'(s0_stall), 64'd1);
        check_eq("s0_hold_valid", 64'(s0_out_valid), 64'd1);
        s0_out_ready = 1'b1;
        step();
        check_eq("s0_empty", 64'(s0_out_valid), 64'd0);

        // SKID=1 back-pressure: 1 in main, 2 in skid, 3 waits
        do_reset();
        s1_out_ready = 1'b0; s1_in_valid = 1'b1;
        s1_in_data = 16'h0001; s1_in_ctrl = 4'h1; s1_in_inst = 32'h1;
        step();
        check_eq("bp_e1_valid", 64'(s1_out_valid), 64'd1);
        check_eq("bp_e1_data", 64'(s1_out_data), 64'h1);
        check_eq("bp_e1_ready", 64'(s1_in_ready), 64'd1);
        s1_in_data = 16'h0002; s1_in_ctrl = 4'h2; s1_in_inst = 32'h2;
        step();
        check_eq("bp_e2_ready", 64'(s1_in_ready), 64'd0);
        check_eq("bp_e2_data", 64'(s1_out_data), 64'h1);
        s1_in_data = 16'h0003; s1_in_ctrl = 4'h3; s1_in_inst = 32'h3;
        step();
        check_eq("bp_e3_ready", 64'(s1_in_ready), 64'd0);
        check_eq("bp_e3_data", 64'(s1_out_data), 64'h1);
        check_eq("bp_e3_stall", 64'(s1_stall), 64'd2);
        s1_out_ready = 1'b1;
        step();
        check_eq("bp_out2_data", 64'(s1_out_data), 64'h2);
        check_eq("bp_out2_ctrl", 64'(s1_out_ctrl), 64'h2);
        check_eq("bp_out2_ready", 64'(s1_in_ready), 64'd1);
        step();
        s1_in_valid = 1'b0;
        check_eq("bp_out3_data", 64'(s1_out_data), 64'h3);
        check_eq("bp_out3_valid", 64'(s1_out_valid), 64'd1);
        step();
        check_eq("bp_end_valid", 64'(s1_out_valid), 64'd0);
        check_eq("bp_end_stall", 64'(s1_stall), 64'd2);

        // Flush while full with a live input offered
        do_reset();
        s1_out_ready = 1'b0; s1_in_valid = 1'b1;
        s1_in_data = 16'h0007; s1_in_ctrl = 4'h7; s1_in_inst = 32'h7;
        step();
        s1_in_data = 16'h0008; s1_in_ctrl = 4'h8; s1_in_inst = 32'h8;
        step();
        check_eq("fl_full_ready", 64'(s1_in_ready), 64'd0);
        s1_flush = 1'b1; s1_in_data = 16'h0009; s1_in_ctrl = 4'h9; s1_in_inst = 32'h9;
        step();
        s1_flush = 1'b0;
        check_eq("fl_valid", 64'(s1_out_valid), 64'd0);
        check_eq("fl_ready", 64'(s1_in_ready), 64'd1);
        check_eq("fl_ctrl", 64'(s1_out_ctrl), 64'd0);
        check_eq("fl_inst", 64'(s1_out_inst), 64'(NOP));
        check_eq("fl_cnt", 64'(s1_flushc), 64'd1);
        check_eq("fl_stall", 64'(s1_stall), 64'd2);
        s1_in_data = 16'h000A; s1_in_ctrl = 4'hA; s1_in_inst = 32'hA;
        step();
        s1_in_valid = 1'b0;
        check_eq("fl_next_valid", 64'(s1_out_valid), 64'd1);
        check_eq("fl_next_data", 64'(s1_out_data), 64'hA);
        check_eq("fl_cnt_kept", 64'(s1_flushc), 64'd1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 64'(s1_out_valid), 64'd0);
        check_eq("ar_data", 64'(s1_out_data), 64'd0);
        check_eq("ar_inst", 64'(s1_out_inst), 64'(NOP));
        check_eq("ar_ready", 64'(s1_in_ready), 64'd1);
        check_eq("ar_flushc", 64'(s1_flushc), 64'd0);
        rst_n = 1'b1;
        s1_in_valid = 1'b1; s1_out_ready = 1'b1;
        s1_in_data = 16'h000B; s1_in_ctrl = 4'h5; s1_in_inst = 32'hBB;
        step();
        s1_in_valid = 1'b0;
        check_eq("ar_post_valid", 64'(s1_out_valid), 64'd1);
        check_eq("ar_post_data", 64'(s1_out_data), 64'hB);
        check_eq("ar_post_ctrl", 64'(s1_out_ctrl), 64'h5);

        // Counter saturation on the 4-bit instance
        do_reset();
        repeat (10) step();
        check_eq("sat_bubble_10", 64'(s2_bubble), 64'd10);
        repeat (10) step();
        check_eq("sat_bubble_20", 64'(s2_bubble), 64'd15);
        step();
        check_eq("sat_bubble_21", 64'(s2_bubble), 64'd15);
        check_eq("sat_stall", 64'(s2_stall), 64'd0);
        check_eq("sat_flushc", 64'(s2_flushc), 64'd0);
        check_eq("sat_idle_valid", 64'(s2_out_valid), 64'd0);
        check_eq("sat_idle_ready", 64'(s2_in_ready), 64'd1);
        check_eq("sat_idle_inst", 64'(s2_out_inst), 64'(NOP));
        check_eq("sat_idle_ctrl", 64'(s2_out_ctrl), 64'd0);
        check_eq("sat_idle_data", 64'(s2_out_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
